spi_mem_ctrl: RTL and testbench

Serial-memory master that sits between the CPU bus interface and the external SPI flash and SPI SRAM chips. It accepts one single-byte read or write request at a time. Each request becomes a standard 40-bit SPI transaction: 8-bit command, 24-bit address MSB first, then 8 data bits. The result is returned on a one-cycle response strobe. Writes to flash are refused without touching the bus.

---
 rtl/spi_mem_ctrl.sv | 103 ++++++++++
 tb/tb_spi_mem_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_ctrl.sv
// Single-byte SPI memory master: 40-bit frame (cmd, 24-bit addr, data) to flash or RAM.
// Flash writes are refused with resp_err, without touching the SPI bus.
module spi_mem_ctrl #(
  parameter int HALF_PERIOD = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_sel,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        resp_valid,
  output logic [7:0]  resp_rdata,
  output logic        resp_err,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_flash_ce,
  output logic        spi_ram_ce
);

  localparam int HPW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e          state_q, state_d;
  logic [HPW-1:0]  hp_cnt_q;
  logic            phase_q;
  logic [5:0]      bit_cnt_q;
  logic [39:0]     shift_q;
  logic [7:0]      rdata_q;
  logic            write_q;
  logic            sel_q;
  logic            accept;
  logic            half_end;
  logic            bit_end;

  assign accept   = req_valid && (state_q == IDLE);
  assign half_end = (hp_cnt_q == HPW'(HALF_PERIOD - 1));
  assign bit_end  = (state_q == SHIFT) && phase_q && half_end;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (req_write && !req_sel) ? DONE : SHIFT;
      SHIFT:   if (bit_end && (bit_cnt_q == 6'd39)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // phase_q is the spi_clk level; mosi advances only at the end of a high phase
  always_ff @(posedge clk) begin
    if (rst) begin
      hp_cnt_q  <= '0;
      phase_q   <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rdata_q   <= '0;
      write_q   <= 1'b0;
      sel_q     <= 1'b0;
    end else if (accept) begin
      hp_cnt_q  <= '0;
      phase_q   <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= {(req_write ? 8'h02 : 8'h03), req_addr, (req_write ? req_wdata : 8'h00)};
      rdata_q   <= '0;
      write_q   <= req_write;
      sel_q     <= req_sel;
    end else if (state_q == SHIFT) begin
      if (half_end) begin
        hp_cnt_q <= '0;
        phase_q  <= ~phase_q;
        if (phase_q) begin
          shift_q   <= {shift_q[38:0], 1'b0};
          bit_cnt_q <= bit_cnt_q + 6'd1;
          if (bit_cnt_q >= 6'd32) rdata_q <= {rdata_q[6:0], spi_miso};
        end
      end else begin
        hp_cnt_q <= hp_cnt_q + HPW'(1);
      end
    end
  end

  always_comb begin
    req_ready    = (state_q == IDLE);
    resp_valid   = (state_q == DONE);
    resp_err     = (state_q == DONE) && write_q && !sel_q;
    resp_rdata   = ((state_q == DONE) && !write_q) ? rdata_q : 8'h00;
    spi_clk      = (state_q == SHIFT) && phase_q;
    spi_mosi     = (state_q == SHIFT) && shift_q[39];
    spi_flash_ce = !((state_q == SHIFT) && !sel_q);
    spi_ram_ce   = !((state_q == SHIFT) && sel_q);
  end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed bench for spi_mem_ctrl: one HALF_PERIOD=1 instance and one HALF_PERIOD=3 instance
// sharing a behavioural SPI flash/RAM model.
module tb_spi_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, req_sel;
  logic [23:0] req_addr;
  logic [7:0]  req_wdata;
  logic        slow_sel;
  logic        m_miso;

  logic        f_rdy, f_vld, f_err, f_sclk, f_mosi, f_fce, f_rce;
  logic [7:0]  f_rdata;
  logic        s_rdy, s_vld, s_err, s_sclk, s_mosi, s_fce, s_rce;
  logic [7:0]  s_rdata;

  logic        r_rdy, r_vld, r_err, r_sclk, r_mosi, r_fce, r_rce;
  logic [7:0]  r_rdata;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_mem_ctrl #(.HALF_PERIOD(1)) u_fast (
    .clk(clk), .rst(rst), .req_valid(req_valid && !slow_sel), .req_ready(f_rdy),
    .req_write(req_write), .req_sel(req_sel), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(f_vld), .resp_rdata(f_rdata), .resp_err(f_err),
    .spi_clk(f_sclk), .spi_mosi(f_mosi), .spi_miso(m_miso),
    .spi_flash_ce(f_fce), .spi_ram_ce(f_rce)
  );

  spi_mem_ctrl #(.HALF_PERIOD(3)) u_slow (
    .clk(clk), .rst(rst), .req_valid(req_valid && slow_sel), .req_ready(s_rdy),
    .req_write(req_write), .req_sel(req_sel), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(s_vld), .resp_rdata(s_rdata), .resp_err(s_err),
    .spi_clk(s_sclk), .spi_mosi(s_mosi), .spi_miso(m_miso),
    .spi_flash_ce(s_fce), .spi_ram_ce(s_rce)
  );

  assign r_rdy   = slow_sel ? s_rdy   : f_rdy;
  assign r_vld   = slow_sel ? s_vld   : f_vld;
  assign r_err   = slow_sel ? s_err   : f_err;
  assign r_rdata = slow_sel ? s_rdata : f_rdata;
  assign r_sclk  = slow_sel ? s_sclk  : f_sclk;
  assign r_mosi  = slow_sel ? s_mosi  : f_mosi;
  assign r_fce   = slow_sel ? s_fce   : f_fce;
  assign r_rce   = slow_sel ? s_rce   : f_rce;

  // Behavioural SPI memories: capture on rising spi_clk, drive read data on the same edge
  logic [7:0]  flash_mem [0:255];
  logic [7:0]  ram_mem   [0:255];
  int          mk = 0;
  logic [39:0] mframe = '0;
  logic [39:0] cap_frame = '0;
  logic [7:0]  m_cmd = '0;
  logic [7:0]  m_addr = '0;
  logic        m_ram = 1'b0;
  logic [7:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic [7:0]  m_byte;

  initial m_miso = 1'b0;

  always @(negedge r_fce or negedge r_rce) begin
    mk     = 0;
    mframe = '0;
    m_ram  = !r_rce;
  end

  always @(posedge r_sclk) begin
    if (!r_fce || !r_rce) begin
      mframe = {mframe[38:0], r_mosi};
      if (mk == 31) begin
        m_cmd  = mframe[31:24];
        m_addr = mframe[7:0];
      end
      if (mk >= 32 && mk <= 39 && m_cmd == 8'h03) begin
        m_byte = m_ram ? ram_mem[m_addr] : flash_mem[m_addr];
        m_miso = m_byte[39 - mk];
      end
      mk = mk + 1;
    end
  end

  always @(posedge r_fce or posedge r_rce) begin
    if (mk == 40) begin
      cap_frame = mframe;
      if (m_cmd == 8'h02) begin
        if (m_ram) ram_mem[m_addr] = mframe[7:0];
        else       flash_mem[m_addr] = mframe[7:0];
        wr_addr = m_addr;
        wr_data = mframe[7:0];
      end
    end
    mk = 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic w, input logic s, input logic [23:0] a, input logic [7:0] d);
    chk("ready_before_req", r_rdy, 1);
    req_write = w;
    req_sel   = s;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Starts at T+1; returns with the response cycle index relative to T
  task automatic wait_resp(output int lat, output int ram_lo, output int fl_lo, output int clk_hi);
    lat = 1; ram_lo = 0; fl_lo = 0; clk_hi = 0;
    while (r_vld !== 1'b1 && lat < 2000) begin
      if (r_rce == 1'b0) ram_lo++;
      if (r_fce == 1'b0) fl_lo++;
      if (r_sclk == 1'b1) clk_hi++;
      tick();
      lat++;
    end
  endtask

  int lat, ram_lo, fl_lo, clk_hi, seen;

  initial begin
    for (int i = 0; i < 256; i++) begin
      flash_mem[i] = 8'h00;
      ram_mem[i]   = 8'h00;
    end
    flash_mem[0] = 8'h3E;
    flash_mem[1] = 8'h03;
    flash_mem[8] = 8'hC2;
    ram_mem[0]   = 8'h5A;
    ram_mem[1]   = 8'hA5;

    slow_sel = 1'b0;
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_sel = 1'b0;
    req_addr = '0; req_wdata = '0;
    tick(); tick();
    chk("rst_ready", r_rdy, 1);
    chk("rst_resp_valid", r_vld, 0);
    chk("rst_rdata", r_rdata, 8'h00);
    chk("rst_err", r_err, 0);
    chk("rst_sclk", r_sclk, 0);
    chk("rst_mosi", r_mosi, 0);
    chk("rst_flash_ce", r_fce, 1);
    chk("rst_ram_ce", r_rce, 1);
    rst = 1'b0;
    tick();

    // RAM read of 0x000001
    issue(1'b0, 1'b1, 24'h000001, 8'h00);
    wait_resp(lat, ram_lo, fl_lo, clk_hi);
    chk("rd_latency", lat, 81);
    chk("rd_rdata", r_rdata, 8'hA5);
    chk("rd_err", r_err, 0);
    chk("rd_ram_ce_cycles", ram_lo, 80);
    chk("rd_flash_ce_cycles", fl_lo, 0);
    chk("rd_ready_in_done", r_rdy, 0);
    chk("rd_done_sclk", r_sclk, 0);
    chk("rd_done_ram_ce", r_rce, 1);
    chk("rd_mosi_hdr", cap_frame[39:8], 32'h03000001);
    tick();
    chk("rd_resp_one_cycle", r_vld, 0);
    chk("rd_ready_after", r_rdy, 1);

    // RAM write 0x3C to 0x10, then read it back
    issue(1'b1, 1'b1, 24'h000010, 8'h3C);
    wait_resp(lat, ram_lo, fl_lo, clk_hi);
    chk("wr_latency", lat, 81);
    chk("wr_rdata", r_rdata, 8'h00);
    chk("wr_err", r_err, 0);
    chk("wr_frame", cap_frame, 40'h020000103C);
    chk("wr_model_addr", wr_addr, 8'h10);
    chk("wr_model_data", wr_data, 8'h3C);
    tick();
    issue(1'b0, 1'b1, 24'h000010, 8'h00);
    wait_resp(lat, ram_lo, fl_lo, clk_hi);
    chk("rdback_rdata", r_rdata, 8'h3C);
    tick();

    // Flash write is refused
    issue(1'b1, 1'b0, 24'h000000, 8'h55);
    wait_resp(lat, ram_lo, fl_lo, clk_hi);
    chk("fw_latency", lat, 1);
    chk("fw_err", r_err, 1);
    chk("fw_rdata", r_rdata, 8'h00);
    chk("fw_flash_ce", r_fce, 1);
    chk("fw_ram_ce", r_rce, 1);
    chk("fw_sclk", r_sclk, 0);
    chk("fw_ready_in_done", r_rdy, 0);
    tick();
    chk("fw_ready_t2", r_rdy, 1);
    chk("fw_resp_clear", r_vld, 0);

    // Flash read on the HALF_PERIOD=3 instance
    slow_sel = 1'b1;
    tick();
    issue(1'b0, 1'b0, 24'h000008, 8'h00);
    wait_resp(lat, ram_lo, fl_lo, clk_hi);
    chk("slow_latency", lat, 241);
    chk("slow_rdata", r_rdata, 8'hC2);
    chk("slow_err", r_err, 0);
    chk("slow_sclk_high_cycles", clk_hi, 120);
    chk("slow_flash_ce_cycles", fl_lo, 240);
    chk("slow_ram_ce_cycles", ram_lo, 0);
    tick();
    slow_sel = 1'b0;
    tick();

    // Reset in the middle of a RAM read
    issue(1'b0, 1'b1, 24'h000001, 8'h00);
    for (int i = 0; i < 39; i++) tick();
    chk("mid_ram_ce_active", r_rce, 0);
    rst = 1'b1;
    tick();
    chk("abort_ram_ce", r_rce, 1);
    chk("abort_sclk", r_sclk, 0);
    chk("abort_ready", r_rdy, 1);
    chk("abort_resp_valid", r_vld, 0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (r_vld === 1'b1) seen++;
      tick();
    end
    chk("abort_no_resp", seen, 0);
    issue(1'b0, 1'b1, 24'h000000, 8'h00);
    wait_resp(lat, ram_lo, fl_lo, clk_hi);
    chk("post_abort_latency", lat, 81);
    chk("post_abort_rdata", r_rdata, 8'h5A);
    tick();

    // Back-to-back flash reads with req_valid held high
    req_write = 1'b0;
    req_sel   = 1'b0;
    req_addr  = 24'h000000;
    req_valid = 1'b1;
    tick();
    req_addr = 24'h000001;
    wait_resp(lat, ram_lo, fl_lo, clk_hi);
    chk("b2b_first_latency", lat, 81);
    chk("b2b_first_rdata", r_rdata, 8'h3E);
    tick();
    chk("b2b_gap_ready", r_rdy, 1);
    chk("b2b_gap_flash_ce", r_fce, 1);
    tick();
    req_valid = 1'b0;
    chk("b2b_second_accept", r_fce, 0);
    wait_resp(lat, ram_lo, fl_lo, clk_hi);
    chk("b2b_second_latency", lat, 81);
    chk("b2b_second_rdata", r_rdata, 8'h03);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
